// File: rtl/ofm_sram_rd_stream.sv
// Read-side streamer for the 2048x8 OFM SRAM: sweeps an address window and
// streams words out on valid/ready (m_*), with credit-limited 1-word/cycle reads.
// Ports: clk, rst (sync, active-high), start/base_addr/len (command),
//   busy/done (status), sram_write_en/sram_addr/sram_rdata (SRAM),
//   m_valid/m_ready/m_data/m_last (stream).
// Optional: define OFM_RD_RELU_EN to clamp negative words to 0 at FIFO push.
module ofm_sram_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 11,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  base_addr,
  input  logic [ADDR_BITS:0]    len,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_write_en,
  output logic [ADDR_BITS-1:0]  sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  logic [1:0]            state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [ADDR_BITS:0]    rd_rem_q, rd_rem_d;
  logic [ADDR_BITS:0]    out_rem_q, out_rem_d;
  logic                  pend_q, pend_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] push_data;

  assign sram_write_en = 1'b0;
  assign sram_addr     = addr_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign m_valid       = (cnt_q != 2'd0);
  assign m_data        = mem_q[rd_ptr_q];
  assign m_last        = m_valid & (out_rem_q == 1);

  assign pop  = m_valid & m_ready;
  assign push = pend_q;

  // Buffer occupancy after this cycle's pop, counting the read in flight.
  assign occ = {1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, pop};

  assign issue = (state_q == S_RUN) && (rd_rem_q != 0) && (occ < DEPTH);

`ifdef OFM_RD_RELU_EN
  assign push_data = sram_rdata[DATA_WIDTH-1] ? '0 : sram_rdata;
`else
  assign push_data = sram_rdata;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_rem_d  = rd_rem_q;
    out_rem_d = out_rem_q;
    done_d    = 1'b0;
    pend_d    = issue;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != 0) begin
            state_d   = S_RUN;
            addr_d    = base_addr;
            rd_rem_d  = len;
            out_rem_d = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d   = addr_q + 1'b1;
          rd_rem_d = rd_rem_q - 1'b1;
          if (rd_rem_q == 1)
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && m_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      out_rem_d = out_rem_q - 1'b1;
      rd_ptr_d  = ~rd_ptr_q;
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rd_rem_q  <= '0;
      out_rem_q <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_rem_q  <= rd_rem_d;
      out_rem_q <= out_rem_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      mem_q[0]  <= mem_d[0];
      mem_q[1]  <= mem_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(issue && (occ >= DEPTH)))
        else $error("read issued without buffer credit");
      assert (!(push && !pop && (cnt_q == 2'd2)))
        else $error("output buffer overflow");
      assert (!sram_write_en)
        else $error("write enable asserted");
    end
  end
`endif

endmodule

// File: tb/tb_ofm_sram_rd_stream.sv
// Scoreboard bench for ofm_sram_rd_stream: directed frames push expected
// beats into a queue, a negedge monitor pops and compares each accepted beat.
module tb_ofm_sram_rd_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] len;
  logic        busy;
  logic        done;
  logic        sram_write_en;
  logic [10:0] sram_addr;
  logic [7:0]  sram_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;

  always #5 clk = ~clk;

  ofm_sram_rd_stream dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .sram_write_en(sram_write_en),
    .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  logic [7:0] mem [2048];
  initial sram_rdata = 8'h00;
  always @(posedge clk) sram_rdata <= mem[sram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [8:0] sb [$];

  int  beats;
  int  first_cyc;
  int  last_cyc;
  int  done_cyc;
  int  start_cyc;
  bit  seen_valid;
  bit  done_seen;
  int  ready_mode = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [10:0] a);
    logic [7:0] b;
    b = a[7:0];
`ifdef OFM_RD_RELU_EN
    if (b[7]) b = 8'h00;
`endif
    return b;
  endfunction

  // m_ready pattern: 1 always, or 1010.. with a 20-cycle low burst.
  int rcnt = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      if (start) rcnt = 0;
      else rcnt++;
      #1;
      if (ready_mode == 0)
        m_ready = 1'b1;
      else if (rcnt >= 20 && rcnt < 40)
        m_ready = 1'b0;
      else
        m_ready = ~rcnt[0];
    end
  end

  bit         stall_prev = 0;
  logic [7:0] hold_data;
  logic       hold_last;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      chk("write_en", int'(sram_write_en), 0);
      if (stall_prev) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), int'(hold_data));
        chk("hold_last", int'(m_last), int'(hold_last));
      end
      if (m_valid && !seen_valid) begin
        seen_valid = 1;
        first_cyc  = cyc;
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", int'({m_last, m_data}), -1);
        end else begin
          chk("beat", int'({m_last, m_data}), int'(sb.pop_front()));
        end
        beats++;
        last_cyc = cyc;
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      stall_prev = m_valid && !m_ready;
      hold_data  = m_data;
      hold_last  = m_last;
    end
  end

  task automatic fill_seq(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [10:0] a;
      a = 11'((b + i) % 2048);
      sb.push_back({(i == n - 1), exp_byte(a)});
    end
  endtask

  task automatic do_start(input int b, input int n);
    @(negedge clk);
    base_addr  = 11'(b);
    len        = 12'(n);
    start      = 1'b1;
    seen_valid = 0;
    done_seen  = 0;
    beats      = 0;
    start_cyc  = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", int'(busy), (n != 0) ? 1 : 0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (!done_seen) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    end
    @(posedge clk);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_last", int'(m_last), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_addr", int'(sram_addr), 0);
    chk("rst_we", int'(sram_write_en), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic frame at full rate
    ready_mode = 0;
    fill_seq(100, 784);
    do_start(100, 784);
    wait_done("basic", 1000);
    chk("basic_beats", beats, 784);
    chk("basic_first_lat", first_cyc - start_cyc, 3);
    chk("basic_last_lat", last_cyc - start_cyc, 786);
    chk("basic_done_lat", done_cyc - last_cyc, 1);
    chk("basic_idle", int'(busy), 0);

    // Backpressure
    ready_mode = 1;
    fill_seq(500, 16);
    do_start(500, 16);
    wait_done("bp", 300);
    chk("bp_beats", beats, 16);
    ready_mode = 0;

    // Address wrap
    fill_seq(2040, 16);
    do_start(2040, 16);
    wait_done("wrap", 100);
    chk("wrap_beats", beats, 16);

    // Single word
    fill_seq(7, 1);
    do_start(7, 1);
    wait_done("len1", 50);
    chk("len1_beats", beats, 1);
    chk("len1_first_lat", first_cyc - start_cyc, 3);

    // Zero length: no beats, done at cycle 1
    do_start(33, 0);
    wait_done("len0", 20);
    chk("len0_beats", beats, 0);
    chk("len0_done_lat", done_cyc - start_cyc, 1);

    // Full array
    fill_seq(0, 2048);
    do_start(0, 2048);
    wait_done("full", 2300);
    chk("full_beats", beats, 2048);

    // Reset mid-frame at beat 300
    fill_seq(100, 784);
    do_start(100, 784);
    for (int n = 0; n < 1000 && beats < 300; n++) @(posedge clk);
    chk("mid_reached", (beats >= 300) ? 1 : 0, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_valid", int'(m_valid), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_addr", int'(sram_addr), 0);
    fill_seq(0, 8);
    do_start(0, 8);
    wait_done("after_rst", 50);
    chk("after_rst_beats", beats, 8);

    // Sign clamp words
    mem[1000] = 8'h7F;
    mem[1001] = 8'h80;
    mem[1002] = 8'hFF;
    mem[1003] = 8'h01;
`ifdef OFM_RD_RELU_EN
    sb.push_back({1'b0, 8'h7F});
    sb.push_back({1'b0, 8'h00});
    sb.push_back({1'b0, 8'h00});
    sb.push_back({1'b1, 8'h01});
`else
    sb.push_back({1'b0, 8'h7F});
    sb.push_back({1'b0, 8'h80});
    sb.push_back({1'b0, 8'hFF});
    sb.push_back({1'b1, 8'h01});
`endif
    do_start(1000, 4);
    wait_done("relu", 50);
    chk("relu_beats", beats, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
